pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard and flush controller for the Aquila core; the next generation of the core's pipeline controller. It combines hazard detection with the flush and stall outputs for the fetch, decode, execute and memory pipeline registers, and sits between the decode, execute and writeback stages. It detects load-use hazards for a configurable load latency, and tracks in-flight multi-cycle (mul/div) results with a register scoreboard. It also freezes the whole pipeline on data-memory stalls and resolves simultaneous flush, stall and hazard events by fixed priority.

## Interface
- RF_AW, 5, register-file address width; 2^RF_AW scoreboard entries.
- LD_LAT, 1, bubble cycles a load needs before its result can be forwarded; legal range 1..4.
- BRANCH_PRED, 1, 1: flush only on predictor miss or unpredicted taken branch; 0: flush on every taken branch.

- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rs1_addr_i, rs2_addr_i  in  RF_AW  source registers of instr in DEC.
- rs1_used_i, rs2_used_i  in  1  instr in DEC actually reads rs1 / rs2.
- is_mc_instr_DEC_i  in  1  instr in DEC is mul/div.
- illegal_instr_i  in  1  instr in DEC is illegal.
- rd_addr_DEC_EXE_i  in  RF_AW  destination of instr in DEC_EXE.
- rd_we_DEC_EXE_i, is_load_instr_DEC_EXE_i, is_mc_instr_DEC_EXE_i  in  1  DEC_EXE attributes.
- mc_wb_i  in  1  a multi-cycle result is written back this cycle.
- mc_wb_rd_i  in  RF_AW  destination of that write-back.
- cond_branch_hit_EXE_i, uncond_branch_hit_EXE_i  in  1  predictor hit flags for the branch in EXE.
- branch_taken_i, cond_branch_misprediction_i  in  1  EXE branch resolution.
- sys_jump_i  in  1  trap/return redirect.
- mem_stall_i  in  1  data memory busy.
- flush2fet_o, flush2dec_o, flush2exe_o, flush2mem_o  out  1  flush the FET_DEC, DEC_EXE, EXE_MEM and MEM_WB registers.
- stall_from_hazard_o  out  1  hold PC and FET_DEC.
- stall_all_o  out  1  hold every pipeline register.
- stall_cnt_o, flush_cnt_o  out  32  performance counters; present only with HAZARD_PERF_CNT_EN.

## Operation
- br_flush = BRANCH_PRED ? (taken & !cond_hit & !uncond_hit) | cond_mispredict : taken.
- Register x0 never causes a hazard. An unused source never causes a hazard.
- Load shadow: shift register of LD_LAT-1 entries {valid, rd}.
  - Entry 0 loads {is_load & rd_we, rd_addr_DEC_EXE_i}; the register shifts each cycle in which stall_all_o=0.
  - sys_jump_i clears all entries.
- ld_use: a used source of the DEC instr matches a DEC_EXE load rd, or matches any valid shadow entry.
- Scoreboard pending[2^RF_AW]:
  - Set: pending[rd_addr_DEC_EXE_i] is set when is_mc & rd_we & rd≠0 & !stall_all_o.
  - Clear: pending[mc_wb_rd_i] is cleared on mc_wb_i.
  - Set and clear of the same index in the same cycle: set wins.
  - sys_jump_i does not clear the scoreboard; the in-flight op still writes back.
- mc_raw: a used source of the DEC instr is pending, or equals the rd of an mc instr in DEC_EXE.
- mc_busy: is_mc_instr_DEC_i while any entry is pending or an mc instr is in DEC_EXE. Only one mc op is allowed in flight.
- hazard = (ld_use | mc_raw | mc_busy) & !br_flush & !sys_jump_i.
- Outputs when mem_stall_i=0:
  - flush2fet_o = br_flush | sys_jump_i.
  - flush2dec_o = br_flush | hazard | illegal_instr_i | sys_jump_i.
  - flush2exe_o = flush2mem_o = sys_jump_i.
  - stall_from_hazard_o = hazard.
  - stall_all_o = 0.
- Outputs when mem_stall_i=1:
  - stall_all_o = 1; all flush outputs and stall_from_hazard_o are 0.
  - State is held, except that scoreboard clears from mc_wb_i still apply.
  - Upstream holds its event inputs until the stall releases.

## Timing
- All outputs are combinational from inputs and current state, valid in the same cycle.
- State updates on the rising edge after the event.
- Reset: shadow and scoreboard cleared, counters 0. With all inputs 0, every output is 0.
- rst_i asserted mid-operation discards pending entries regardless of in-flight ops.
- Load followed immediately by a consumer: exactly LD_LAT bubble cycles.
- mc op: pending is visible the cycle after it leaves DEC_EXE. Its consumer stalls through the mc_wb_i cycle and is released the following cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o increments on every cycle with stall_from_hazard_o | stall_all_o.
  - flush_cnt_o increments on every cycle with flush2fet_o.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by rst_i.
- HAZARD_PERF_CNT_EN undefined: counters and their ports are absent.

## Test plan
- LD_LAT=2; load x5 in DEC_EXE; DEC reads x5 with rs1_used_i=1 -> stall_from_hazard_o=1 for 2 cycles, flush2dec_o=1 for 2 cycles. Same sequence with rs1_used_i=0 -> no stall.
- mc writes x7; consumer of x7 in DEC -> stall held until mc_wb_i with mc_wb_rd_i=7, released the next cycle. A second mc op in DEC meanwhile -> mc_busy stall.
- Hazard and br_flush in the same cycle (taken=1, no hit) -> flush2fet_o=1, flush2dec_o=1, stall_from_hazard_o=0.
- mem_stall_i=1 together with sys_jump_i=1 -> all flush outputs 0, stall_all_o=1. After release -> all four flushes = 1 and the shadow is cleared.
- Load to x0 followed by a reader of x0 -> no stall. BRANCH_PRED=0 with taken=1 and cond_hit=1 -> flush2fet_o=1.
- With HAZARD_PERF_CNT_EN: 3 stall cycles plus 2 flushes -> stall_cnt_o=3, flush_cnt_o=2. rst_i -> both 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle; counter ports exist only with HAZARD_PERF_CNT_EN
interface pipeline_hazard_ctrl_if #(
  parameter int RF_AW = 5
);
  logic [RF_AW-1:0] rs1_addr_i;
  logic [RF_AW-1:0] rs2_addr_i;
  logic             rs1_used_i;
  logic             rs2_used_i;
  logic             is_mc_instr_DEC_i;
  logic             illegal_instr_i;
  logic [RF_AW-1:0] rd_addr_DEC_EXE_i;
  logic             rd_we_DEC_EXE_i;
  logic             is_load_instr_DEC_EXE_i;
  logic             is_mc_instr_DEC_EXE_i;
  logic             mc_wb_i;
  logic [RF_AW-1:0] mc_wb_rd_i;
  logic             cond_branch_hit_EXE_i;
  logic             uncond_branch_hit_EXE_i;
  logic             branch_taken_i;
  logic             cond_branch_misprediction_i;
  logic             sys_jump_i;
  logic             mem_stall_i;
  logic             flush2fet_o;
  logic             flush2dec_o;
  logic             flush2exe_o;
  logic             flush2mem_o;
  logic             stall_from_hazard_o;
  logic             stall_all_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      stall_cnt_o;
  logic [31:0]      flush_cnt_o;
`endif

  // Pipeline side: drives stage status, receives flush/stall controls
  modport master (
    output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
    output is_mc_instr_DEC_i, illegal_instr_i,
    output rd_addr_DEC_EXE_i, rd_we_DEC_EXE_i, is_load_instr_DEC_EXE_i, is_mc_instr_DEC_EXE_i,
    output mc_wb_i, mc_wb_rd_i,
    output cond_branch_hit_EXE_i, uncond_branch_hit_EXE_i, branch_taken_i, cond_branch_misprediction_i,
    output sys_jump_i, mem_stall_i,
    input  flush2fet_o, flush2dec_o, flush2exe_o, flush2mem_o,
    input  stall_from_hazard_o,
    input  stall_all_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  stall_cnt_o,
    input  flush_cnt_o
`endif
  );

  // Controller side
  modport slave (
    input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
    input  is_mc_instr_DEC_i, illegal_instr_i,
    input  rd_addr_DEC_EXE_i, rd_we_DEC_EXE_i, is_load_instr_DEC_EXE_i, is_mc_instr_DEC_EXE_i,
    input  mc_wb_i, mc_wb_rd_i,
    input  cond_branch_hit_EXE_i, uncond_branch_hit_EXE_i, branch_taken_i, cond_branch_misprediction_i,
    input  sys_jump_i, mem_stall_i,
    output flush2fet_o, flush2dec_o, flush2exe_o, flush2mem_o,
    output stall_from_hazard_o,
    output stall_all_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output stall_cnt_o,
    output flush_cnt_o
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use / mul-div hazard, flush and stall control; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl #(
  parameter int RF_AW       = 5,
  parameter int LD_LAT      = 1,
  parameter bit BRANCH_PRED = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int NREG = 1 << RF_AW;
  localparam int SH_N = (LD_LAT > 1) ? LD_LAT - 1 : 1;

  logic             br_flush;
  logic             rs1_live;
  logic             rs2_live;
  logic             de_load;
  logic             de_mc;
  logic             de_rs_match;
  logic             shadow_hit;
  logic             ld_use;
  logic             mc_raw;
  logic             mc_busy;
  logic             hazard;
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic [SH_N-1:0]  sh_valid;
  logic [RF_AW-1:0] sh_rd [SH_N];

  // x0 and unused sources can never create a dependency
  assign rs1_live = hz.rs1_used_i && (hz.rs1_addr_i != '0);
  assign rs2_live = hz.rs2_used_i && (hz.rs2_addr_i != '0);

  assign de_load     = hz.is_load_instr_DEC_EXE_i && hz.rd_we_DEC_EXE_i;
  assign de_mc       = hz.is_mc_instr_DEC_EXE_i && hz.rd_we_DEC_EXE_i;
  assign de_rs_match = (rs1_live && (hz.rs1_addr_i == hz.rd_addr_DEC_EXE_i)) ||
                       (rs2_live && (hz.rs2_addr_i == hz.rd_addr_DEC_EXE_i));

  // With a predictor only unpredicted redirects flush; otherwise any taken branch does
  assign br_flush = BRANCH_PRED
                  ? ((hz.branch_taken_i && !hz.cond_branch_hit_EXE_i && !hz.uncond_branch_hit_EXE_i) ||
                     hz.cond_branch_misprediction_i)
                  : hz.branch_taken_i;

  generate
    if (LD_LAT > 1) begin : g_shadow
      // Load shadow: remembers loads that left DEC_EXE but are not yet forwardable
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sh_valid <= '0;
          for (int i = 0; i < SH_N; i++) sh_rd[i] <= '0;
        end else if (!hz.mem_stall_i) begin
          if (hz.sys_jump_i) begin
            sh_valid <= '0;
          end else begin
            sh_valid[0] <= de_load;
            sh_rd[0]    <= hz.rd_addr_DEC_EXE_i;
            for (int i = 1; i < SH_N; i++) begin
              sh_valid[i] <= sh_valid[i-1];
              sh_rd[i]    <= sh_rd[i-1];
            end
          end
        end
      end
    end else begin : g_no_shadow
      assign sh_valid = '0;
      assign sh_rd[0] = '0;
    end
  endgenerate

  // Any valid shadow entry matching a live source is a load-use dependency
  always_comb begin
    shadow_hit = 1'b0;
    for (int i = 0; i < SH_N; i++) begin
      if (sh_valid[i] &&
          ((rs1_live && (hz.rs1_addr_i == sh_rd[i])) ||
           (rs2_live && (hz.rs2_addr_i == sh_rd[i])))) begin
        shadow_hit = 1'b1;
      end
    end
  end

  // Scoreboard next state: write-back clears always apply, issue sets only while not frozen; set wins
  always_comb begin
    pending_nxt = pending;
    if (hz.mc_wb_i) pending_nxt[hz.mc_wb_rd_i] = 1'b0;
    if (de_mc && (hz.rd_addr_DEC_EXE_i != '0) && !hz.mem_stall_i)
      pending_nxt[hz.rd_addr_DEC_EXE_i] = 1'b1;
  end

  // Scoreboard register; survives trap redirects because the op still writes back
  always_ff @(posedge clk_i) begin
    if (rst_i) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign ld_use  = (de_load && de_rs_match) || shadow_hit;
  assign mc_raw  = (rs1_live && pending[hz.rs1_addr_i]) ||
                   (rs2_live && pending[hz.rs2_addr_i]) ||
                   (de_mc && de_rs_match);
  assign mc_busy = hz.is_mc_instr_DEC_i && ((|pending) || hz.is_mc_instr_DEC_EXE_i);
  assign hazard  = (ld_use || mc_raw || mc_busy) && !br_flush && !hz.sys_jump_i;

  // Output priority: memory stall freezes everything, then redirects, then hazards
  always_comb begin
    hz.flush2fet_o         = 1'b0;
    hz.flush2dec_o         = 1'b0;
    hz.flush2exe_o         = 1'b0;
    hz.flush2mem_o         = 1'b0;
    hz.stall_from_hazard_o = 1'b0;
    hz.stall_all_o         = 1'b0;
    if (hz.mem_stall_i) begin
      hz.stall_all_o = 1'b1;
    end else begin
      hz.flush2fet_o         = br_flush || hz.sys_jump_i;
      hz.flush2dec_o         = br_flush || hazard || hz.illegal_instr_i || hz.sys_jump_i;
      hz.flush2exe_o         = hz.sys_jump_i;
      hz.flush2mem_o         = hz.sys_jump_i;
      hz.stall_from_hazard_o = hazard;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Free-running wrap-around counters of stall and front-end flush cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.stall_from_hazard_o || hz.stall_all_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hz.flush2fet_o)                           flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int RF_AW  = 5;
  localparam int LD_LAT = 2;
  localparam int NREG   = 1 << RF_AW;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  int          ld_remain [NREG];
  bit          m_pend    [NREG];
  logic [5:0]  exp_vec;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;

  pipeline_hazard_ctrl_if #(.RF_AW(RF_AW)) hz ();
  pipeline_hazard_ctrl_if #(.RF_AW(RF_AW)) hz_np ();

  pipeline_hazard_ctrl #(.RF_AW(RF_AW), .LD_LAT(LD_LAT), .BRANCH_PRED(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hz(hz)
  );
  pipeline_hazard_ctrl #(.RF_AW(RF_AW), .LD_LAT(LD_LAT), .BRANCH_PRED(1'b0)) dut_np (
    .clk_i(clk_i), .rst_i(rst_i), .hz(hz_np)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {flush2fet, flush2dec, flush2exe, flush2mem, stall_from_hazard, stall_all}
  function automatic logic [5:0] obs();
    return {hz.flush2fet_o, hz.flush2dec_o, hz.flush2exe_o, hz.flush2mem_o,
            hz.stall_from_hazard_o, hz.stall_all_o};
  endfunction

  task automatic clr_inputs();
    hz.rs1_addr_i = '0;                  hz.rs2_addr_i = '0;
    hz.rs1_used_i = 1'b0;                hz.rs2_used_i = 1'b0;
    hz.is_mc_instr_DEC_i = 1'b0;         hz.illegal_instr_i = 1'b0;
    hz.rd_addr_DEC_EXE_i = '0;           hz.rd_we_DEC_EXE_i = 1'b0;
    hz.is_load_instr_DEC_EXE_i = 1'b0;   hz.is_mc_instr_DEC_EXE_i = 1'b0;
    hz.mc_wb_i = 1'b0;                   hz.mc_wb_rd_i = '0;
    hz.cond_branch_hit_EXE_i = 1'b0;     hz.uncond_branch_hit_EXE_i = 1'b0;
    hz.branch_taken_i = 1'b0;            hz.cond_branch_misprediction_i = 1'b0;
    hz.sys_jump_i = 1'b0;                hz.mem_stall_i = 1'b0;
  endtask

  task automatic clr_np();
    hz_np.rs1_addr_i = '0;                hz_np.rs2_addr_i = '0;
    hz_np.rs1_used_i = 1'b0;              hz_np.rs2_used_i = 1'b0;
    hz_np.is_mc_instr_DEC_i = 1'b0;       hz_np.illegal_instr_i = 1'b0;
    hz_np.rd_addr_DEC_EXE_i = '0;         hz_np.rd_we_DEC_EXE_i = 1'b0;
    hz_np.is_load_instr_DEC_EXE_i = 1'b0; hz_np.is_mc_instr_DEC_EXE_i = 1'b0;
    hz_np.mc_wb_i = 1'b0;                 hz_np.mc_wb_rd_i = '0;
    hz_np.cond_branch_hit_EXE_i = 1'b0;   hz_np.uncond_branch_hit_EXE_i = 1'b0;
    hz_np.branch_taken_i = 1'b0;          hz_np.cond_branch_misprediction_i = 1'b0;
    hz_np.sys_jump_i = 1'b0;              hz_np.mem_stall_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Reference model: per-register countdown of remaining load bubbles plus a pending bitmap
  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      ld_remain[r] = 0;
      m_pend[r]    = 1'b0;
    end
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  task automatic model_expect();
    bit br, ld, raw, busy, haz, anyp;
    int src   [2];
    bit used  [2];
    br  = (hz.branch_taken_i && !hz.cond_branch_hit_EXE_i && !hz.uncond_branch_hit_EXE_i) ||
          hz.cond_branch_misprediction_i;
    src[0] = int'(hz.rs1_addr_i);  used[0] = hz.rs1_used_i;
    src[1] = int'(hz.rs2_addr_i);  used[1] = hz.rs2_used_i;
    ld = 1'b0;
    raw = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (used[s] && src[s] != 0) begin
        if (hz.rd_we_DEC_EXE_i && src[s] == int'(hz.rd_addr_DEC_EXE_i)) begin
          if (hz.is_load_instr_DEC_EXE_i) ld = 1'b1;
          if (hz.is_mc_instr_DEC_EXE_i)   raw = 1'b1;
        end
        if (ld_remain[src[s]] > 0) ld = 1'b1;
        if (m_pend[src[s]])        raw = 1'b1;
      end
    end
    anyp = 1'b0;
    for (int r = 0; r < NREG; r++) if (m_pend[r]) anyp = 1'b1;
    busy = hz.is_mc_instr_DEC_i && (anyp || hz.is_mc_instr_DEC_EXE_i);
    haz  = (ld || raw || busy) && !br && !hz.sys_jump_i;
    if (hz.mem_stall_i)
      exp_vec = 6'b000001;
    else
      exp_vec = {br || hz.sys_jump_i,
                 br || haz || hz.illegal_instr_i || hz.sys_jump_i,
                 hz.sys_jump_i, hz.sys_jump_i, haz, 1'b0};
  endtask

  task automatic model_step();
    if (rst_i) begin
      model_reset();
    end else begin
      if (exp_vec[1] || exp_vec[0]) m_stall_cnt = m_stall_cnt + 32'd1;
      if (exp_vec[5])               m_flush_cnt = m_flush_cnt + 32'd1;
      if (hz.mc_wb_i) m_pend[hz.mc_wb_rd_i] = 1'b0;
      if (!hz.mem_stall_i) begin
        if (hz.is_mc_instr_DEC_EXE_i && hz.rd_we_DEC_EXE_i && hz.rd_addr_DEC_EXE_i != '0)
          m_pend[hz.rd_addr_DEC_EXE_i] = 1'b1;
        for (int r = 0; r < NREG; r++) begin
          if (hz.sys_jump_i)      ld_remain[r] = 0;
          else if (ld_remain[r] > 0) ld_remain[r] = ld_remain[r] - 1;
        end
        if (!hz.sys_jump_i && hz.is_load_instr_DEC_EXE_i && hz.rd_we_DEC_EXE_i)
          ld_remain[hz.rd_addr_DEC_EXE_i] = LD_LAT - 1;
      end
    end
  endtask

  task automatic test_reset();
    clr_np();
    do_reset();
    #1;
    n_checks++;
    if (obs() !== 6'b000000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs(), 6'b000000);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (hz.stall_cnt_o !== 32'd0 || hz.flush_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", hz.stall_cnt_o, hz.flush_cnt_o);
    end
`endif
  endtask

  task automatic test_load_use();
    logic [5:0] want [3];
    want[0] = 6'b010010; want[1] = 6'b010010; want[2] = 6'b000000;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clr_inputs();
      hz.rs1_addr_i = 5'd5; hz.rs1_used_i = 1'b1;
      if (c == 0) begin
        hz.is_load_instr_DEC_EXE_i = 1'b1; hz.rd_we_DEC_EXE_i = 1'b1; hz.rd_addr_DEC_EXE_i = 5'd5;
      end
      #1;
      n_checks++;
      if (obs() !== want[c]) begin
        n_fail++; $display("FAIL load_use_c%0d: got %b expected %b", c, obs(), want[c]);
      end
      step();
    end
    do_reset();
    for (int c = 0; c < 2; c++) begin
      clr_inputs();
      hz.rs1_addr_i = 5'd5; hz.rs1_used_i = 1'b0;
      if (c == 0) begin
        hz.is_load_instr_DEC_EXE_i = 1'b1; hz.rd_we_DEC_EXE_i = 1'b1; hz.rd_addr_DEC_EXE_i = 5'd5;
      end
      #1;
      n_checks++;
      if (obs() !== 6'b000000) begin
        n_fail++; $display("FAIL load_unused_c%0d: got %b expected %b", c, obs(), 6'b000000);
      end
      step();
    end
  endtask

  task automatic test_multicycle();
    logic [5:0] want [6];
    want = '{6'b010010, 6'b010010, 6'b010010, 6'b010010, 6'b000000, 6'b000000};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clr_inputs();
      hz.rs1_addr_i = 5'd7; hz.rs1_used_i = 1'b1;
      case (c)
        0: begin hz.is_mc_instr_DEC_EXE_i = 1'b1; hz.rd_we_DEC_EXE_i = 1'b1; hz.rd_addr_DEC_EXE_i = 5'd7; end
        2: begin hz.rs1_used_i = 1'b0; hz.is_mc_instr_DEC_i = 1'b1; end
        3: begin hz.mc_wb_i = 1'b1; hz.mc_wb_rd_i = 5'd7; end
        5: begin hz.rs1_used_i = 1'b0; hz.is_mc_instr_DEC_i = 1'b1; end
        default: ;
      endcase
      #1;
      n_checks++;
      if (obs() !== want[c]) begin
        n_fail++; $display("FAIL mc_c%0d: got %b expected %b", c, obs(), want[c]);
      end
      step();
    end
  endtask

  task automatic test_flush_priority();
    do_reset();
    hz.is_load_instr_DEC_EXE_i = 1'b1; hz.rd_we_DEC_EXE_i = 1'b1; hz.rd_addr_DEC_EXE_i = 5'd5;
    hz.rs2_addr_i = 5'd5; hz.rs2_used_i = 1'b1;
    hz.branch_taken_i = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 6'b110000) begin
      n_fail++; $display("FAIL flush_over_hazard: got %b expected %b", obs(), 6'b110000);
    end
    hz.cond_branch_hit_EXE_i = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 6'b010010) begin
      n_fail++; $display("FAIL predicted_branch_hazard: got %b expected %b", obs(), 6'b010010);
    end
  endtask

  task automatic test_mem_stall_jump();
    do_reset();
    hz.is_load_instr_DEC_EXE_i = 1'b1; hz.rd_we_DEC_EXE_i = 1'b1; hz.rd_addr_DEC_EXE_i = 5'd9;
    step();
    clr_inputs();
    hz.mem_stall_i = 1'b1;
    step();
    step();
    hz.mem_stall_i = 1'b0;
    hz.rs1_addr_i = 5'd9; hz.rs1_used_i = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 6'b010010) begin
      n_fail++; $display("FAIL shadow_held_in_stall: got %b expected %b", obs(), 6'b010010);
    end
    do_reset();
    hz.mem_stall_i = 1'b1; hz.sys_jump_i = 1'b1;
    hz.rs1_addr_i = 5'd9; hz.rs1_used_i = 1'b1;
    hz.is_load_instr_DEC_EXE_i = 1'b1; hz.rd_we_DEC_EXE_i = 1'b1; hz.rd_addr_DEC_EXE_i = 5'd9;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (obs() !== 6'b000001) begin
        n_fail++; $display("FAIL stall_with_jump_c%0d: got %b expected %b", c, obs(), 6'b000001);
      end
      step();
    end
    hz.mem_stall_i = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 6'b111100) begin
      n_fail++; $display("FAIL jump_release: got %b expected %b", obs(), 6'b111100);
    end
    step();
    clr_inputs();
    hz.rs1_addr_i = 5'd9; hz.rs1_used_i = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 6'b000000) begin
      n_fail++; $display("FAIL shadow_cleared_by_jump: got %b expected %b", obs(), 6'b000000);
    end
  endtask

  task automatic test_x0_and_nopred();
    do_reset();
    hz.is_load_instr_DEC_EXE_i = 1'b1; hz.rd_we_DEC_EXE_i = 1'b1; hz.rd_addr_DEC_EXE_i = 5'd0;
    hz.rs1_used_i = 1'b1; hz.rs2_used_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (obs() !== 6'b000000) begin
        n_fail++; $display("FAIL x0_load_c%0d: got %b expected %b", c, obs(), 6'b000000);
      end
      step();
      hz.is_load_instr_DEC_EXE_i = 1'b0; hz.rd_we_DEC_EXE_i = 1'b0;
    end
    clr_inputs();
    hz.branch_taken_i = 1'b1; hz.cond_branch_hit_EXE_i = 1'b1;
    hz_np.branch_taken_i = 1'b1; hz_np.cond_branch_hit_EXE_i = 1'b1;
    #1;
    n_checks++;
    if (hz_np.flush2fet_o !== 1'b1) begin
      n_fail++; $display("FAIL nopred_taken_flush: got %b expected 1", hz_np.flush2fet_o);
    end
    n_checks++;
    if (hz.flush2fet_o !== 1'b0) begin
      n_fail++; $display("FAIL pred_hit_no_flush: got %b expected 0", hz.flush2fet_o);
    end
    clr_np();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    hz.mem_stall_i = 1'b1;
    repeat (3) step();
    hz.mem_stall_i = 1'b0; hz.branch_taken_i = 1'b1;
    repeat (2) step();
    clr_inputs();
    #1;
    n_checks++;
    if (hz.stall_cnt_o !== 32'd3 || hz.flush_cnt_o !== 32'd2) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d expected 3/2", hz.stall_cnt_o, hz.flush_cnt_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_checks++;
    if (hz.stall_cnt_o !== 32'd0 || hz.flush_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", hz.stall_cnt_o, hz.flush_cnt_o);
    end
  endtask
`endif

  task automatic test_random();
    int k;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      clr_inputs();
      hz.rs1_addr_i = RF_AW'($urandom_range(0, 3));
      hz.rs2_addr_i = RF_AW'($urandom_range(0, 3));
      hz.rs1_used_i = ($urandom_range(0, 3) != 0);
      hz.rs2_used_i = ($urandom_range(0, 1) != 0);
      hz.is_mc_instr_DEC_i = ($urandom_range(0, 7) == 0);
      hz.illegal_instr_i = ($urandom_range(0, 15) == 0);
      k = int'($urandom_range(0, 7));
      hz.is_load_instr_DEC_EXE_i = (k < 2);
      hz.is_mc_instr_DEC_EXE_i = (k == 2);
      hz.rd_we_DEC_EXE_i = (k <= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      hz.rd_addr_DEC_EXE_i = RF_AW'($urandom_range(0, 3));
      hz.mc_wb_i = ($urandom_range(0, 5) == 0);
      hz.mc_wb_rd_i = RF_AW'($urandom_range(0, 3));
      hz.branch_taken_i = ($urandom_range(0, 7) == 0);
      hz.cond_branch_hit_EXE_i = ($urandom_range(0, 1) == 0);
      hz.uncond_branch_hit_EXE_i = ($urandom_range(0, 3) == 0);
      hz.cond_branch_misprediction_i = ($urandom_range(0, 15) == 0);
      hz.sys_jump_i = ($urandom_range(0, 31) == 0);
      hz.mem_stall_i = ($urandom_range(0, 7) == 0);
      rst_i = ($urandom_range(0, 199) == 0);
      #1;
      model_expect();
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL random_c%0d: got %b expected %b", c, obs(), exp_vec);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (hz.stall_cnt_o !== m_stall_cnt || hz.flush_cnt_o !== m_flush_cnt) begin
        n_fail++; $display("FAIL random_cnt_c%0d: got %0d/%0d expected %0d/%0d",
                           c, hz.stall_cnt_o, hz.flush_cnt_o, m_stall_cnt, m_flush_cnt);
      end
`endif
      @(posedge clk_i);
      model_step();
      #1;
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multicycle();
    test_flush_priority();
    test_mem_stall_jump();
    test_x0_and_nopred();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
